// File: rtl/pipe_ex_hs.sv
// Three-stage flow-controlled pipeline computing F = ((A + B) + (C - D)) * D
// with per-transaction wrap/saturate mode, overflow flag and bubble collapsing.
module pipe_ex_hs #(
  parameter int unsigned N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] F,
  output logic         ovf
);

  // s1 + d1 can reach 3*2^N - 3, so x2 keeps one bit beyond N+2 to stay exact.
  localparam int unsigned XW = N + 3;
  localparam int unsigned PW = 2 * N + 4;

  logic                 v1, v2, v3;
  logic                 e1, e2, e3;
  logic [N:0]           s1;
  logic signed [N:0]    d1;
  logic [N-1:0]         dd1, dd2;
  logic                 m1, m2;
  logic signed [XW-1:0] x2;

  logic signed [PW-1:0] xe, de, p;
  logic                 neg, big;
  logic [N-1:0]         f_nxt;
  logic                 ovf_nxt;

  assign e3        = ~v3 | out_ready;
  assign e2        = ~v2 | e3;
  assign e1        = ~v1 | e2;
  assign in_ready  = e1;
  assign out_valid = v3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      s1  <= '0;
      d1  <= '0;
      dd1 <= '0;
      m1  <= 1'b0;
    end else if (e1) begin
      v1  <= in_valid;
      s1  <= {1'b0, A} + {1'b0, B};
      d1  <= $signed({1'b0, C}) - $signed({1'b0, D});
      dd1 <= D;
      m1  <= mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      x2  <= '0;
      dd2 <= '0;
      m2  <= 1'b0;
    end else if (e2) begin
      v2  <= v1;
      x2  <= $signed({2'b00, s1}) + $signed({{2{d1[N]}}, d1});
      dd2 <= dd1;
      m2  <= m1;
    end
  end

  always_comb begin
    xe      = {{(PW - XW){x2[XW-1]}}, x2};
    de      = {{(PW - N){1'b0}}, dd2};
    p       = xe * de;
    neg     = p[PW-1];
    big     = ~neg && (p[PW-2:N] != '0);
    ovf_nxt = neg | big;
    f_nxt   = p[N-1:0];
    if (m2 && neg) begin
      f_nxt = '0;
    end else if (m2 && big) begin
      f_nxt = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3  <= 1'b0;
      F   <= '0;
      ovf <= 1'b0;
    end else if (e3) begin
      v3  <= v2;
      F   <= f_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_ex_hs.sv
// Bench for pipe_ex_hs: vector table, hand-written handshake sequences and a
// randomized run checked by an integer-arithmetic scoreboard.
module tb_pipe_ex_hs;

  localparam int unsigned N  = 10;
  localparam int unsigned NV = 13;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B, C, D;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] F;
  logic         ovf;

  typedef struct {
    logic [N-1:0] a, b, c, d;
    logic         m;
    logic [N-1:0] f;
    logic         o;
  } vec_t;

  typedef struct {
    logic [N-1:0] f;
    logic         o;
  } res_t;

  vec_t tv [NV];
  res_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic         held;
  logic [N-1:0] held_f;
  logic         held_o;

  pipe_ex_hs #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .D(D), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // True integer result of the formula, then wrapped or clamped to N bits.
  function automatic void model(input logic [N-1:0] a, b, c, d, input logic m,
                                output logic [N-1:0] f, output logic o);
    longint x, p, lim;
    lim = (longint'(1) << N) - 1;
    x   = longint'(a) + longint'(b) + (longint'(c) - longint'(d));
    p   = x * longint'(d);
    o   = (p < 0) || (p > lim);
    if (m && p < 0)        f = '0;
    else if (m && p > lim) f = '1;
    else                   f = N'(p & lim);
  endfunction

  task automatic drive(input logic v, input vec_t t, input logic r);
    in_valid  = v;
    A         = t.a;
    B         = t.b;
    C         = t.c;
    D         = t.d;
    mode      = t.m;
    out_ready = r;
  endtask

  // Scoreboard: transfers are decided by values stable across the falling edge.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      check("sb_in_ready", in_ready, (q.size() < 3) || out_ready);
      if (held) begin
        check("sb_hold_valid", out_valid, 1);
        check("sb_hold_F", F, held_f);
        check("sb_hold_ovf", ovf, held_o);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("sb_spurious_out_valid", out_valid, 0);
        end else if (out_ready) begin
          e = q.pop_front();
          check("sb_F", F, e.f);
          check("sb_ovf", ovf, e.o);
        end
      end
      held   = out_valid && !out_ready;
      held_f = F;
      held_o = ovf;
      if (in_valid && in_ready) begin
        model(A, B, C, D, mode, e.f, e.o);
        q.push_back(e);
      end
    end
  end

  initial begin
    vec_t rv;
    int   sent, rcv;
    logic exp_rdy;

    tv[0]  = '{10'd10,   10'd12,   10'd6,    10'd3,    1'b0, 10'd75,   1'b0};
    tv[1]  = '{10'd10,   10'd10,   10'd5,    10'd3,    1'b0, 10'd66,   1'b0};
    tv[2]  = '{10'd20,   10'd11,   10'd1,    10'd4,    1'b0, 10'd112,  1'b0};
    tv[3]  = '{10'd15,   10'd10,   10'd8,    10'd2,    1'b0, 10'd62,   1'b0};
    tv[4]  = '{10'd8,    10'd15,   10'd5,    10'd0,    1'b0, 10'd0,    1'b0};
    // 2046 * 1023 = 2093058, whose low ten bits are 2.
    tv[5]  = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b0, 10'd2,    1'b1};
    tv[6]  = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b1, 10'd1023, 1'b1};
    tv[7]  = '{10'd0,    10'd0,    10'd0,    10'd5,    1'b0, 10'd999,  1'b1};
    tv[8]  = '{10'd0,    10'd0,    10'd0,    10'd5,    1'b1, 10'd0,    1'b1};
    tv[9]  = '{10'd0,    10'd0,    10'd0,    10'd5,    1'b0, 10'd999,  1'b1};
    tv[10] = '{10'd0,    10'd0,    10'd0,    10'd5,    1'b1, 10'd0,    1'b1};
    tv[11] = '{10'd0,    10'd0,    10'd0,    10'd5,    1'b0, 10'd999,  1'b1};
    tv[12] = '{10'd0,    10'd0,    10'd0,    10'd5,    1'b1, 10'd0,    1'b1};

    held = 1'b0;
    rst  = 1'b1;
    drive(1'b0, tv[0], 1'b0);
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_F", F, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming table: vector j accepted at the next edge, shown three edges on.
    for (int j = 0; j < int'(NV) + 3; j++) begin
      if (j < int'(NV)) drive(1'b1, tv[j], 1'b1);
      else              drive(1'b0, tv[0], 1'b1);
      @(negedge clk);
      if (j == 2) check("lat_not_yet_valid", out_valid, 0);
      if (j >= 3) begin
        check($sformatf("tv%0d_valid", j - 3), out_valid, 1);
        check($sformatf("tv%0d_F", j - 3), F, tv[j-3].f);
        check($sformatf("tv%0d_ovf", j - 3), ovf, tv[j-3].o);
      end
      @(posedge clk); #1;
    end

    // Backpressure: five sets offered while the consumer stalls for 8 cycles.
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      drive(sent < 5, tv[(sent < 5) ? sent : 0], cyc >= 8);
      @(negedge clk);
      exp_rdy = ((sent - rcv) < 3) || out_ready;
      check("bp_in_ready", in_ready, exp_rdy);
      if (out_valid && !out_ready) check("bp_held_F", F, 75);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (rcv < 5) begin
          check($sformatf("bp_out%0d_F", rcv), F, tv[rcv].f);
        end else begin
          check("bp_extra_result", out_valid, 0);
        end
        rcv++;
      end
      @(posedge clk); #1;
    end
    check("bp_sent", sent, 5);
    check("bp_received", rcv, 5);

    // Bubble collapse: X, two idle cycles, Y, then Z while the output stalls.
    for (int it = 0; it < 11; it++) begin
      case (it)
        0:       drive(1'b1, tv[0], 1'b0);
        3:       drive(1'b1, tv[1], 1'b0);
        6:       drive(1'b1, tv[2], 1'b0);
        default: drive(1'b0, tv[0], it >= 8);
      endcase
      @(negedge clk);
      if (it <= 6) check($sformatf("bc_in_ready_%0d", it), in_ready, 1);
      if (it == 5) check("bc_x_waiting_F", F, 75);
      if (it == 7) check("bc_full_in_ready", in_ready, 0);
      if (it >= 8) begin
        check($sformatf("bc_out%0d_valid", it - 8), out_valid, 1);
        check($sformatf("bc_out%0d_F", it - 8), F, tv[it-8].f);
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset with three results held in the pipe.
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, tv[j], 1'b0);
      @(posedge clk); #1;
    end
    drive(1'b0, tv[0], 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_F", F, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    rv = '{10'd30, 10'd1, 10'd2, 10'd4, 1'b0, 10'd116, 1'b0};
    for (int j = 0; j < 4; j++) begin
      drive(j == 0, rv, 1'b1);
      @(negedge clk);
      if (j == 2) check("post_rst_lat_valid", out_valid, 0);
      if (j == 3) begin
        check("post_rst_valid", out_valid, 1);
        check("post_rst_F", F, 116);
      end
      @(posedge clk); #1;
    end

    // Randomized traffic against the scoreboard, with corner operands mixed in.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: rv = '{'1, '1, '1, '1, 1'b0, '0, 1'b0};
        1: begin
          rv = '{'0, '0, '0, '0, 1'b0, '0, 1'b0};
          rv.d = N'($urandom);
        end
        default: begin
          rv.a = N'($urandom);
          rv.b = N'($urandom);
          rv.c = N'($urandom);
          rv.d = N'($urandom);
        end
      endcase
      rv.m = 1'($urandom);
      drive($urandom_range(0, 3) != 0, rv, $urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, tv[0], 1'b1);
      @(posedge clk); #1;
    end
    check("drain_queue_empty", q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
